// File: rtl/fpu_pkg.sv
// Shared types and constants for the FPU vector runner: op codes, vector layout,
// runner state encoding and single-precision classification helpers.
package fpu_pkg;

  localparam logic [1:0]  FPU_OP_ADD = 2'b00;
  localparam logic [1:0]  FPU_OP_SUB = 2'b01;
  localparam logic [1:0]  FPU_OP_MUL = 2'b10;

  localparam logic [31:0] F32_QNAN = 32'h7FC00000;
  localparam logic [31:0] F32_ONE  = 32'h3F800000;

  typedef struct packed {
    logic [31:0] A;
    logic [31:0] B;
    logic [1:0]  sel;
    logic [31:0] exp;
  } fpu_vec_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_SEND,
    ST_WAIT_RES,
    ST_CHECK,
    ST_DONE
  } runner_state_t;

  function automatic logic f32_is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic logic f32_is_zero(input logic [31:0] x);
    return x[30:0] == 31'd0;
  endfunction

endpackage

// File: rtl/fpu_vec_runner_cmp.sv
// Result comparator: any NaN matches any NaN, +0 matches -0, otherwise bit-exact.
module fpu_result_cmp
  import fpu_pkg::*;
(
  input  logic [31:0] got,
  input  logic [31:0] exp,
  output logic        match
);

  always_comb begin
    match = (f32_is_nan(got) && f32_is_nan(exp)) ||
            (f32_is_zero(got) && f32_is_zero(exp)) ||
            (got == exp);
  end

endmodule

// File: rtl/fpu_vec_runner.sv
// Streams test vectors from a memory through an FPU one transaction at a time and
// scores the results. Define FPU_RUNNER_BACKPRESSURE_EN to throttle result_rdy with an LFSR.
module fpu_vec_runner
  import fpu_pkg::*;
#(
  parameter int VEC_AW  = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [VEC_AW:0]   num_vecs,
  output logic              busy,
  output logic              done,
  output logic              vec_rd_en,
  output logic [VEC_AW-1:0] vec_addr,
  input  logic [97:0]       vec_rd_data,
  output logic              operands_val,
  output logic [31:0]       operands_bits_A,
  output logic [31:0]       operands_bits_B,
  output logic [1:0]        operands_sel,
  input  logic              operands_rdy,
  input  logic              result_val,
  input  logic [31:0]       result_bits,
  output logic              result_rdy,
  output logic [15:0]       fail_count,
  output logic [VEC_AW-1:0] first_fail_idx,
  output logic              first_fail_vld,
  output logic              timeout_flag,
  output logic [31:0]       last_got
);

  localparam int TW = $clog2(TIMEOUT + 1);

  runner_state_t     state, state_nxt;
  fpu_vec_t          vec_q;
  logic [VEC_AW-1:0] idx;
  logic [VEC_AW:0]   num_q;
  logic [TW-1:0]     wait_cnt;
  logic              hs_op, hs_res, match, last_vec, wait_expired;
  logic              timeout_hit, count_fail, rdy_gate;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

`ifdef FPU_RUNNER_BACKPRESSURE_EN
  logic [15:0] lfsr;
  always_ff @(posedge clk) begin
    if (reset) lfsr <= 16'hACE1;
    else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
  assign rdy_gate = lfsr[0];
`else
  assign rdy_gate = 1'b1;
`endif

  fpu_result_cmp u_cmp (
    .got   (last_got),
    .exp   (vec_q.exp),
    .match (match)
  );

  assign busy            = (state != ST_IDLE);
  assign done            = (state == ST_DONE);
  assign vec_rd_en       = (state == ST_FETCH);
  assign vec_addr        = idx;
  assign operands_val    = (state == ST_SEND);
  assign operands_bits_A = vec_q.A;
  assign operands_bits_B = vec_q.B;
  assign operands_sel    = vec_q.sel;
  assign result_rdy      = (state == ST_WAIT_RES) && rdy_gate;

  assign hs_op        = operands_val && operands_rdy;
  assign hs_res       = result_val && result_rdy;
  assign last_vec     = ({1'b0, idx} == num_q - (VEC_AW + 1)'(1));
  assign wait_expired = (wait_cnt == TW'(TIMEOUT - 1));
  // A stall expires only in a cycle where the pending handshake did not complete.
  assign timeout_hit  = wait_expired &&
                        (((state == ST_SEND) && !hs_op) || ((state == ST_WAIT_RES) && !hs_res));
  assign count_fail   = timeout_hit || ((state == ST_CHECK) && !match);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (start) state_nxt = (num_vecs == '0) ? ST_DONE : ST_FETCH;
      ST_FETCH:    state_nxt = ST_LOAD;
      ST_LOAD:     state_nxt = ST_SEND;
      ST_SEND:     if (hs_op) state_nxt = ST_WAIT_RES;
                   else if (timeout_hit) state_nxt = ST_DONE;
      ST_WAIT_RES: if (hs_res) state_nxt = ST_CHECK;
                   else if (timeout_hit) state_nxt = ST_DONE;
      ST_CHECK:    state_nxt = last_vec ? ST_DONE : ST_FETCH;
      ST_DONE:     state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      vec_q          <= '0;
      idx            <= '0;
      num_q          <= '0;
      wait_cnt       <= '0;
      fail_count     <= '0;
      first_fail_idx <= '0;
      first_fail_vld <= 1'b0;
      timeout_flag   <= 1'b0;
      last_got       <= '0;
    end else begin
      state <= state_nxt;
      if ((state == ST_IDLE) && start && (num_vecs != '0)) begin
        idx            <= '0;
        num_q          <= num_vecs;
        fail_count     <= '0;
        first_fail_idx <= '0;
        first_fail_vld <= 1'b0;
        timeout_flag   <= 1'b0;
      end
      if (state == ST_LOAD) vec_q <= vec_rd_data;
      if (hs_res) last_got <= result_bits;
      if ((state == ST_CHECK) && !last_vec) idx <= idx + VEC_AW'(1);
      // The stall counter restarts whenever a handshake state is entered or left.
      if (((state == ST_SEND) || (state == ST_WAIT_RES)) && (state_nxt == state))
        wait_cnt <= wait_cnt + TW'(1);
      else
        wait_cnt <= '0;
      if (count_fail) begin
        fail_count <= sat_inc(fail_count);
        if (!first_fail_vld) begin
          first_fail_idx <= idx;
          first_fail_vld <= 1'b1;
        end
      end
      if (timeout_hit) timeout_flag <= 1'b1;
    end
  end

endmodule
